// File: rtl/pkt_cntr_event_gen.sv
// Packet pipeline monitor: 2-entry skid buffer plus framing tracker
// that emits counter update/decrement pulses for generic_cntr_regs.
module pkt_cntr_event_gen #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int MIN_PKT_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  pkt_consumed,
    output logic [1:0]            updates,
    output logic [1:0]            decrement
);

    typedef struct packed {
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    typedef enum logic {
        HDR,
        PAYLOAD
    } state_t;

    localparam logic [7:0] MIN_W = 8'(MIN_PKT_WORDS);

    word_t       mem0;
    word_t       mem1;
    word_t       in_word;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic        push;
    logic        pop;
    logic        wr_idx;
    state_t      state;
    logic [7:0]  wcnt;
    logic        head_is_ctrl;
    logic        runt;

    assign in_word = '{ctrl: in_ctrl, data: in_data};
    assign push    = in_wr && in_rdy;
    assign out_wr  = (count != 2'd0) && out_rdy;
    assign pop     = out_wr;

    assign out_data = (count != 2'd0) ? mem0.data : '0;
    assign out_ctrl = (count != 2'd0) ? mem0.ctrl : '0;

    // Slot for an incoming word after the head (possibly) shifts out
    assign wr_idx = (count == 2'd2) || ((count == 2'd1) && !pop);

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            push && !pop: count_nxt = count + 2'd1;
            pop && !push: count_nxt = count - 2'd1;
            default:      count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            in_rdy <= 1'b0;
        end else begin
            count  <= count_nxt;
            in_rdy <= (count_nxt < 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !wr_idx) begin
            mem0 <= in_word;
        end else if (pop) begin
            mem0 <= mem1;
        end
        if (push && wr_idx) begin
            mem1 <= in_word;
        end
    end

    assign head_is_ctrl = (mem0.ctrl != '0);
    // Final length includes the EOP word itself
    assign runt = ({1'b0, wcnt} + 9'd1) < {1'b0, MIN_W};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HDR;
            wcnt      <= 8'd0;
            updates   <= 2'b00;
            decrement <= 2'b00;
        end else begin
            updates   <= 2'b00;
            decrement <= {1'b0, pkt_consumed};
            if (out_wr) begin
                unique case (state)
                    HDR: begin
                        if (!head_is_ctrl) begin
                            state <= PAYLOAD;
                            wcnt  <= 8'd1;
                        end
                    end
                    PAYLOAD: begin
                        if (!head_is_ctrl) begin
                            if (wcnt < MIN_W) begin
                                wcnt <= wcnt + 8'd1;
                            end
                        end else begin
                            state   <= HDR;
                            wcnt    <= 8'd0;
                            updates <= {runt, 1'b1};
                        end
                    end
                    default: begin
                        state <= HDR;
                        wcnt  <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule
